proc_control: RTL
=================

Name: proc_control

Overview:
- Control unit for the 16-bit single-bus processor datapath.
- Fetches a 9-bit instruction from din and sequences it over up to four steps (T0..T3).
- Each cycle it produces one-hot bus-driver selects for the register/din/G bus multiplexer, plus load enables for R0..R7, A, G and its internal IR.
- Sits between the top level (run, din) and the register file, ALU and bus mux.

Parameters:
- DATA_W, 16, width of din. Instruction taken from din[DATA_W-1:DATA_W-9].
- N_REGS, 8, number of general registers. Fixed at 8 by the 3-bit register fields.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- resetn  input  1  asynchronous, active-low reset.
- run  input  1  start request, sampled in T0.
- din  input  DATA_W  external data/instruction word.
- ir  output  9  current instruction register {op[2:0], rx[2:0], ry[2:0]}.
- r_out  output  N_REGS  one-hot bus select for R0..R7.
- dinout  output  1  bus select for din.
- g_out  output  1  bus select for G.
- r_in  output  N_REGS  one-hot load enable for R0..R7.
- a_in  output  1  load enable for A.
- g_in  output  1  load enable for G.
- alu_sub  output  1  1 selects A - bus, 0 selects A + bus.
- done  output  1  one-cycle pulse in the final step of an instruction.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous, active-low. resetn low forces state T0 and ir = 0 immediately, including mid-instruction. The partial instruction is abandoned; no further writes occur.
- Output timing: all outputs are combinational from (state, ir, run). No extra latency.
- Reset/T0 output values: r_out = 0, g_out = 0, dinout = 1, r_in = 0, a_in = 0, g_in = 0, alu_sub = 0, done = 0.
- Bus invariant: exactly one of {dinout, r_out[7:0], g_out} is asserted in every state. The bus is never undriven or multiply driven. Checked by assertion.
- Opcodes:
  - 000 mv rx,ry
  - 001 mvi rx,#D (D is the next din word)
  - 010 add rx,ry
  - 011 sub rx,ry
  - 1xx reserved, executed as nop.
- States and transitions:
  - T0: dinout = 1. If run: ir <= din[15:7], go to T1. Else stay in T0.
  - T1, mv: r_out[ry] = 1, r_in[rx] = 1, done = 1; go to T0.
  - T1, mvi: dinout = 1, r_in[rx] = 1, done = 1; go to T0. The testbench presents D on din during this cycle.
  - T1, add/sub: r_out[rx] = 1, a_in = 1; go to T2.
  - T1, reserved: dinout = 1, done = 1, no load enables; go to T0.
  - T2: r_out[ry] = 1, g_in = 1, alu_sub = (op == 011); go to T3.
  - T3: g_out = 1, r_in[rx] = 1, done = 1; go to T0.
- run is ignored outside T0. Deasserting it mid-instruction does not abort.
- run held high: the next instruction is fetched in the T0 following done. Minimum gap is one cycle: mv/mvi = 2 cycles, add/sub = 4 cycles per instruction.
- rx == ry is legal:
  - mv r3,r3 drives and loads R3 in the same cycle (value unchanged).
  - add r3,r3 doubles R3.
- ir holds its value until the next T0 fetch with run = 1.

Decomposition:
- Package proc_pkg holds:
  - opcode constants OP_MV, OP_MVI, OP_ADD, OP_SUB;
  - state encoding T0..T3 as a 2-bit type;
  - field index constants for op/rx/ry.
- Sub-module dec3to8 (3-bit to 8-bit one-hot with enable) is instantiated twice: once for r_out, once for r_in.

Test Plan:
- Reset: hold resetn = 0 with run = 1 and din = 16'hFFFF for 3 cycles, then release. Required: state T0, ir = 0, dinout = 1, all enables 0, done = 0.
- mvi: run = 1, din = {001, 000, 000, 7'b0}, then din = 16'h00A5. Required in T1: dinout = 1, r_in = 8'b0000_0001, done = 1. Total 2 cycles.
- mv r2,r0 after mvi: Required in T1: r_out = 8'b0000_0001, r_in = 8'b0000_0100, done = 1.
- add r1,r2: Required sequence:
  - T1: r_out = 8'h02, a_in = 1.
  - T2: r_out = 8'h04, g_in = 1, alu_sub = 0.
  - T3: g_out = 1, r_in = 8'h02, done = 1.
- sub with run dropped after T0, plus a reserved opcode 111: sub completes all steps with alu_sub = 1 in T2. Reserved opcode gives done in T1 with r_in = 0, a_in = 0, g_in = 0.
- Reset asserted asynchronously in T2 of add: state returns to T0 without waiting for a clock edge. g_in deasserts immediately and no r_in pulse follows. A bus one-hot assertion runs throughout every scenario.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared definitions for the single-bus processor control unit:
// opcodes, step encoding and instruction-register field positions.
package proc_pkg;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    localparam int IR_W  = 9;
    localparam int OP_HI = 8;
    localparam int OP_LO = 6;
    localparam int RX_HI = 5;
    localparam int RX_LO = 3;
    localparam int RY_HI = 2;
    localparam int RY_LO = 0;

endpackage

// File: rtl/dec3to8.sv
// 3-to-8 one-hot decoder with enable; all-zero output when disabled.
module dec3to8 (
    input  logic [2:0] sel_i,
    input  logic       en_i,
    output logic [7:0] y_o
);

    always_comb begin
        y_o = '0;
        if (en_i) begin
            y_o[sel_i] = 1'b1;
        end
    end

endmodule

// File: rtl/proc_control.sv
// Step sequencer (T0..T3) for the 16-bit single-bus processor: fetches a
// 9-bit instruction from din and emits bus selects and load enables.
module proc_control
    import proc_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int N_REGS = 8
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              run,
    input  logic [DATA_W-1:0] din,
    output logic [IR_W-1:0]   ir,
    output logic [N_REGS-1:0] r_out,
    output logic              dinout,
    output logic              g_out,
    output logic [N_REGS-1:0] r_in,
    output logic              a_in,
    output logic              g_in,
    output logic              alu_sub,
    output logic              done
);

    state_t          state_q, state_d;
    logic [IR_W-1:0] ir_q, ir_d;

    logic [2:0] op, rx, ry;
    logic [2:0] rout_sel;
    logic       rout_en;
    logic       rin_en;

    // Only the top nine bits of din form an instruction.
    logic unused_din;
    assign unused_din = ^din[DATA_W-IR_W-1:0];

    assign op = ir_q[OP_HI:OP_LO];
    assign rx = ir_q[RX_HI:RX_LO];
    assign ry = ir_q[RY_HI:RY_LO];
    assign ir = ir_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= T0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        rout_en  = 1'b0;
        rout_sel = ry;
        rin_en   = 1'b0;
        dinout   = 1'b0;
        g_out    = 1'b0;
        a_in     = 1'b0;
        g_in     = 1'b0;
        alu_sub  = 1'b0;
        done     = 1'b0;

        case (state_q)
            T0: begin
                dinout = 1'b1;
                if (run) begin
                    ir_d    = din[DATA_W-1 -: IR_W];
                    state_d = T1;
                end
            end
            T1: begin
                case (op)
                    OP_MV: begin
                        rout_en = 1'b1;
                        rin_en  = 1'b1;
                        done    = 1'b1;
                        state_d = T0;
                    end
                    OP_MVI: begin
                        dinout  = 1'b1;
                        rin_en  = 1'b1;
                        done    = 1'b1;
                        state_d = T0;
                    end
                    OP_ADD, OP_SUB: begin
                        rout_en  = 1'b1;
                        rout_sel = rx;
                        a_in     = 1'b1;
                        state_d  = T2;
                    end
                    default: begin
                        // Reserved opcodes retire as a nop; din keeps the bus driven.
                        dinout  = 1'b1;
                        done    = 1'b1;
                        state_d = T0;
                    end
                endcase
            end
            T2: begin
                rout_en = 1'b1;
                g_in    = 1'b1;
                alu_sub = (op == OP_SUB);
                state_d = T3;
            end
            T3: begin
                g_out   = 1'b1;
                rin_en  = 1'b1;
                done    = 1'b1;
                state_d = T0;
            end
            default: begin
                dinout  = 1'b1;
                state_d = T0;
            end
        endcase
    end

    dec3to8 u_dec_rout (
        .sel_i (rout_sel),
        .en_i  (rout_en),
        .y_o   (r_out)
    );

    dec3to8 u_dec_rin (
        .sel_i (rx),
        .en_i  (rin_en),
        .y_o   (r_in)
    );

endmodule
